lw_sha_msg_sched: RTL and testbench
===================================

// Module: lw_sha_msg_sched
// PURPOSE
//  Masked message-schedule unit for the lightweight SHA core, SHA-256 and SHA-512 on one datapath.
//  Accepts 16 message words per block and streams W[0..N-1] (N=64 or 80) to the round engine.
//  Every word is held in a 16-entry circular buffer in byte-rotated masked form {off, rotr(x, off*8)}.
//  Sits between the padding/input stage and the compression-round engine.
// PARAMETERS
//  WORD_W   64                  datapath width; 32 = SHA-256 only, 64 = SHA-256 and SHA-512
//  ROT_W    $clog2(WORD_W/8)    width of the byte-rotation offset (3 for 64, 2 for 32)
//  IDX_W    7                   width of the W-index output
// PORTS
//  clk        in   1             clock
//  rst        in   1             synchronous reset, active-high
//  start      in   1             begin one block; sampled only in IDLE
//  mode       in   1             1 = SHA-512 (N=80, 64-bit), 0 = SHA-256 (N=64, low 32 bits); latched at start
//  msg_valid  in   1             message word present
//  msg_ready  out  1             message word accepted when msg_valid && msg_ready
//  msg_word   in   WORD_W        plain message word, big-endian word order W[0] first
//  rnd        in   ROT_W         fresh random rotation offset; sampled on every buffer write
//  w_valid    out  1             schedule word available
//  w_ready    in   1             round engine consumes the word
//  w_word     out  ROT_W+WORD_W  masked schedule word {off, rotated word}
//  w_idx      out  IDX_W         index t of w_word
//  busy       out  1             high outside IDLE
//  done       out  1             one-cycle pulse on the cycle W[N-1] is consumed
// BEHAVIOUR
//  - Reset: FSM=IDLE, t=0, msg_ready=0, w_valid=0, w_word=0, w_idx=0, busy=0, done=0. Buffer is not cleared.
//  - Reset mid-block aborts immediately. The partial block is discarded. No done pulse.
//  - FSM states IDLE -> LOAD -> EXPAND -> IDLE.
//  - IDLE: on start, latch mode and set t=0, then go to LOAD. start is ignored in every other state.
//  - Output slot is free when !w_valid || w_ready.
//  - LOAD (t=0..15):
//    - msg_ready = slot free.
//    - On accept, write write_word(msg_word, rnd) into buf[t] and into the output register; w_idx=t; t++.
//    - At t==15 accepted, go to EXPAND.
//  - EXPAND (t=16..N-1):
//    - Unmask buf[(t-2)%16], buf[(t-7)%16], buf[(t-15)%16] and buf[t%16].
//    - Compute W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32 (mode 0) or mod 2^64 (mode 1).
//    - When the slot is free, write masked W[t] into buf[t%16] (overwriting W[t-16]) and the output register; t++.
//    - After W[N-1] is loaded, stop generating. Go to IDLE with done=1 in the cycle W[N-1] is consumed.
//  - Throughput is 1 word/cycle with w_ready held high. Latency from msg accept to w_valid is 1 cycle.
//  - Backpressure: while w_valid && !w_ready, w_word and w_idx stay stable, no buffer write, t frozen.
//  - Simultaneous consume and produce in the same cycle is legal. The register reloads and no bubble is inserted.
//  - Sigma functions:
//    - mode 0: s0 = ROTR7^ROTR18^SHR3, s1 = ROTR17^ROTR19^SHR10 on 32 bits.
//    - mode 1: s0 = ROTR1^ROTR8^SHR7, s1 = ROTR19^ROTR61^SHR6 on 64 bits.
//  - Mode 0 masking:
//    - Rotation stays within the low 32 bits; offset = rnd[1:0], and the MSB of the off field is written 0.
//    - Bits [WORD_W-1:32] of w_word are 0.
//    - The unmask rotates left by off*8 within 32 bits.
//  - WORD_W=32 forces mode=0 internally.
//  - A plain (unmasked) word never appears on any register; unmasking is combinational only into the sigma/adder path.
// STRUCTURE
//  - lw_sha_pkg adds:
//    - sched_state_e enum {IDLE, LOAD, EXPAND}
//    - constants SHA256_ROUNDS=64, SHA512_ROUNDS=80
//    - read_word/write_word generalised to ROT_W-bit offsets with a mode argument
//    - functions sigma0/sigma1(x, mode)
//  - One sub-module, lw_sha_sched_sigma: combinational s0, s1 and the 4-input mode-selected adder.
//  - The 16-entry buffer is a register array, not a RAM: four read ports are needed.
// TESTING
//  - SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x18), rnd=0, w_ready=1
//    -> unmasked W16=0x61626380, W17=0x000F0000; 64 words at 1/cycle; done 1 cycle after W63 handshake.
//  - SHA-512 "abc" block (W0=0x6162638000000000, W15=0x18)
//    -> W16=0x6162638000000000, W17=0x00030000000000C0; done after W79.
//  - Same blocks with random rnd each cycle
//    -> unmasked stream bit-identical to the rnd=0 run; stored off fields match sampled rnd (mode 0 MSB=0).
//  - Random w_ready toggling (~50%)
//    -> w_word/w_idx stable while stalled; no index skipped or repeated; final W identical.
//  - rst asserted at t=40 in EXPAND
//    -> next cycle: busy=0, w_valid=0, no done; a new start then produces a correct full block.
//  - start pulsed during LOAD/EXPAND and msg_valid high in EXPAND
//    -> ignored; msg_ready=0 in EXPAND and IDLE; stream unaffected.

Source files
------------

// File: rtl/lw_sha_pkg.sv
// lw_sha_pkg: shared types plus byte-rotation masking and sigma helpers for the lightweight SHA core
package lw_sha_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND} sched_state_e;

    localparam int SHA256_ROUNDS = 64;
    localparam int SHA512_ROUNDS = 80;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input logic [5:0] n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [63:0] rotl64(input logic [63:0] x, input logic [5:0] n);
        logic [127:0] d;
        d = {x, x} << n;
        return d[127:64];
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    // Masked form is {off, rotr(x, off*8)}; SHA-256 words rotate within the low 32 bits only
    function automatic logic [66:0] write_word(input logic [63:0] x, input logic [2:0] rnd, input logic mode);
        logic [2:0] off;
        off = mode ? rnd : {1'b0, rnd[1:0]};
        return mode ? {off, rotr64(x, {off, 3'b000})}
                    : {off, 32'b0, rotr32(x[31:0], {off[1:0], 3'b000})};
    endfunction

    function automatic logic [63:0] read_word(input logic [66:0] w, input logic mode);
        return mode ? rotl64(w[63:0], {w[66:64], 3'b000})
                    : {32'b0, rotl32(w[31:0], {w[65:64], 3'b000})};
    endfunction

    function automatic logic [63:0] sigma0(input logic [63:0] x, input logic mode);
        logic [31:0] y;
        y = x[31:0];
        return mode ? (rotr64(x, 6'd1) ^ rotr64(x, 6'd8) ^ (x >> 7))
                    : {32'b0, rotr32(y, 5'd7) ^ rotr32(y, 5'd18) ^ (y >> 3)};
    endfunction

    function automatic logic [63:0] sigma1(input logic [63:0] x, input logic mode);
        logic [31:0] y;
        y = x[31:0];
        return mode ? (rotr64(x, 6'd19) ^ rotr64(x, 6'd61) ^ (x >> 6))
                    : {32'b0, rotr32(y, 5'd17) ^ rotr32(y, 5'd19) ^ (y >> 10)};
    endfunction

endpackage

// File: rtl/lw_sha_sched_sigma.sv
// lw_sha_sched_sigma: combinational W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mode-width sum
module lw_sha_sched_sigma
    import lw_sha_pkg::*;
(
    input  logic        mode,
    input  logic [63:0] w2,
    input  logic [63:0] w7,
    input  logic [63:0] w15,
    input  logic [63:0] w16,
    output logic [63:0] w_new
);
    logic [63:0] sum;
    always_comb begin
        sum   = sigma1(w2, mode) + w7 + sigma0(w15, mode) + w16;
        w_new = mode ? sum : {32'b0, sum[31:0]};
    end
endmodule

// File: rtl/lw_sha_msg_sched.sv
// lw_sha_msg_sched: masked SHA-256/512 message schedule; 16-word circular buffer, one W per cycle
module lw_sha_msg_sched
    import lw_sha_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int ROT_W  = $clog2(WORD_W / 8),
    parameter int IDX_W  = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    msg_valid,
    output logic                    msg_ready,
    input  logic [WORD_W-1:0]       msg_word,
    input  logic [ROT_W-1:0]        rnd,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [ROT_W+WORD_W-1:0] w_word,
    output logic [IDX_W-1:0]        w_idx,
    output logic                    busy,
    output logic                    done
);
    localparam int MW = ROT_W + WORD_W;

    sched_state_e     state;
    logic [IDX_W-1:0] t;
    logic [IDX_W-1:0] n_rounds;
    logic             mode_r;
    logic             md;
    logic             slot_free;
    logic             msg_acc;
    logic             gen;
    logic             last_out;
    logic [3:0]       i0, i2, i7, i15;
    logic [63:0]      u2, u7, u15, u16, w_new;
    logic [MW-1:0]    mw_load, mw_exp;
    logic [MW-1:0]    wbuf [16];

    function automatic logic [66:0] widen(input logic [MW-1:0] m);
        return {3'(m[MW-1:WORD_W]), 64'(m[WORD_W-1:0])};
    endfunction

    function automatic logic [MW-1:0] narrow(input logic [66:0] m);
        return {m[64+ROT_W-1:64], m[WORD_W-1:0]};
    endfunction

    // A 32-bit build can only run SHA-256
    always_comb begin
        md        = (WORD_W == 64) && mode_r;
        n_rounds  = md ? IDX_W'(SHA512_ROUNDS) : IDX_W'(SHA256_ROUNDS);
        slot_free = !w_valid || w_ready;
        msg_ready = (state == LOAD) && slot_free;
        msg_acc   = msg_ready && msg_valid;
        gen       = (state == EXPAND) && (t != n_rounds) && slot_free;
        last_out  = (state == EXPAND) && (t == n_rounds) && w_valid && w_ready;
        busy      = state != IDLE;
        i0        = t[3:0];
        i2        = i0 - 4'd2;
        i7        = i0 - 4'd7;
        i15       = i0 + 4'd1;
        u2        = read_word(widen(wbuf[i2]), md);
        u7        = read_word(widen(wbuf[i7]), md);
        u15       = read_word(widen(wbuf[i15]), md);
        u16       = read_word(widen(wbuf[i0]), md);
        mw_load   = narrow(write_word(64'(msg_word), 3'(rnd), md));
        mw_exp    = narrow(write_word(w_new, 3'(rnd), md));
    end

    lw_sha_sched_sigma u_sigma (
        .mode  (md),
        .w2    (u2),
        .w7    (u7),
        .w15   (u15),
        .w16   (u16),
        .w_new (w_new)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            t       <= '0;
            mode_r  <= 1'b0;
            w_valid <= 1'b0;
            w_word  <= '0;
            w_idx   <= '0;
            done    <= 1'b0;
        end else begin
            done <= last_out;
            if (msg_acc || gen) begin
                w_valid <= 1'b1;
                w_word  <= msg_acc ? mw_load : mw_exp;
                w_idx   <= t;
                t       <= t + IDX_W'(1);
            end else if (w_ready) begin
                w_valid <= 1'b0;
            end
            if (state == IDLE && start) begin
                state  <= LOAD;
                mode_r <= mode;
                t      <= '0;
            end else if (msg_acc && t == IDX_W'(15)) begin
                state <= EXPAND;
            end else if (last_out) begin
                state <= IDLE;
            end
        end
    end

    // W[t] overwrites W[t-16], which this cycle's sum has just consumed
    always_ff @(posedge clk) begin
        if (msg_acc || gen) wbuf[i0] <= msg_acc ? mw_load : mw_exp;
    end

endmodule

// File: tb/tb_lw_sha_msg_sched.sv
// tb_lw_sha_msg_sched: directed SHA-256/512 "abc" schedule runs with masking, backpressure, abort and stray inputs
module tb_lw_sha_msg_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        msg_valid = 1'b0;
    logic        w_ready = 1'b0;
    logic [63:0] msg_word = '0;
    logic [2:0]  rnd = '0;
    logic        msg_ready, w_valid, busy, done;
    logic [66:0] w_word;
    logic [6:0]  w_idx;

    int          total = 0;
    int          bad = 0;
    logic [63:0] ref_w [80];
    logic [63:0] blk [16];

    always #5 clk = ~clk;

    lw_sha_msg_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_word  (msg_word),
        .rnd       (rnd),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_word    (w_word),
        .w_idx     (w_idx),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] tr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] ts0(input logic [63:0] x, input logic md);
        logic [31:0] y;
        y = x[31:0];
        return md ? (tr64(x, 1) ^ tr64(x, 8) ^ (x >> 7)) : {32'b0, tr32(y, 7) ^ tr32(y, 18) ^ (y >> 3)};
    endfunction

    function automatic logic [63:0] ts1(input logic [63:0] x, input logic md);
        logic [31:0] y;
        y = x[31:0];
        return md ? (tr64(x, 19) ^ tr64(x, 61) ^ (x >> 6)) : {32'b0, tr32(y, 17) ^ tr32(y, 19) ^ (y >> 10)};
    endfunction

    function automatic logic [63:0] unmask(input logic [66:0] w, input logic md);
        logic [31:0] lo;
        logic [63:0] x;
        int k;
        lo = w[31:0];
        x = w[63:0];
        if (md) begin
            k = 8 * int'(w[66:64]);
            return (x << k) | (x >> (64 - k));
        end
        k = 8 * int'(w[65:64]);
        return {32'b0, (lo << k) | (lo >> (32 - k))};
    endfunction

    task automatic build(input logic md);
        logic [63:0] s;
        for (int i = 0; i < 80; i++) begin
            if (i < 16) s = blk[i];
            else s = ts1(ref_w[i-2], md) + ref_w[i-7] + ts0(ref_w[i-15], md) + ref_w[i-16];
            ref_w[i] = md ? s : {32'b0, s[31:0]};
        end
    endtask

    task automatic load_abc(input logic md);
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = md ? 64'h6162638000000000 : 64'h0000000061626380;
        blk[15] = 64'h18;
    endtask

    task automatic run_block(input logic md, input bit rr, input bit rdy_r, input int abort_at, input bit poke);
        int nxt, exp_idx, cyc, hs_cnt, n;
        logic pv, phs, got_done;
        logic [66:0] pw, got;
        logic [6:0] pi;
        logic [2:0] used;
        nxt = 0; exp_idx = 0; cyc = 0; hs_cnt = 0;
        pv = 1'b0; phs = 1'b0; got_done = 1'b0; pw = '0; pi = '0;
        n = md ? 80 : 64;
        load_abc(md);
        build(md);
        @(negedge clk);
        mode = md;
        start = 1'b1;
        msg_valid = 1'b1;
        w_ready = 1'b1;
        rnd = rr ? 3'($urandom_range(0, 7)) : 3'd0;
        msg_word = md ? blk[0] : {32'($urandom), blk[0][31:0]};
        while (!got_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            used = rnd;
            chk("done", {66'b0, done}, {66'b0, phs && pi == 7'(n - 1)});
            if (done) begin
                got_done = 1'b1;
                chk("busy_after", {66'b0, busy}, 67'd0);
                chk("valid_after", {66'b0, w_valid}, 67'd0);
                chk("idle_msg_ready", {66'b0, msg_ready}, 67'd0);
                chk("hs_count", 67'(hs_cnt), 67'(n));
                if (!rdy_r) chk("cycles", 67'(cyc), 67'(n + 2));
            end else begin
                chk("busy", {66'b0, busy}, 67'd1);
                if (abort_at >= 0 && w_valid && w_idx == 7'(abort_at)) begin
                    rst = 1'b1;
                    @(negedge clk);
                    chk("abort_busy", {66'b0, busy}, 67'd0);
                    chk("abort_valid", {66'b0, w_valid}, 67'd0);
                    chk("abort_done", {66'b0, done}, 67'd0);
                    chk("abort_msg_ready", {66'b0, msg_ready}, 67'd0);
                    rst = 1'b0;
                    return;
                end
                if (w_valid && pv && !phs) begin
                    chk("stall_word", w_word, pw);
                    chk("stall_idx", 67'(w_idx), 67'(pi));
                end
                if (w_valid && (!pv || phs)) begin
                    chk("idx", 67'(w_idx), 67'(exp_idx));
                    chk("off", 67'(w_word[66:64]), md ? 67'(used) : 67'({1'b0, used[1:0]}));
                    if (!md) chk("hi_zero", 67'(w_word[63:32]), 67'd0);
                    got = 67'(unmask(w_word, md));
                    chk("word", got, 67'(ref_w[exp_idx]));
                    if (exp_idx == 16) chk("w16_hand", got, md ? 67'h6162638000000000 : 67'h61626380);
                    if (exp_idx == 17) chk("w17_hand", got, md ? 67'h00030000000000C0 : 67'h000F0000);
                    exp_idx++;
                end
                if (nxt == 16) chk("msg_ready_expand", {66'b0, msg_ready}, 67'd0);
            end
            start = poke && (cyc == 5 || cyc == 30);
            w_ready = rdy_r ? 1'($urandom_range(0, 1)) : 1'b1;
            rnd = rr ? 3'($urandom_range(0, 7)) : 3'd0;
            if (nxt < 16) msg_word = md ? blk[nxt] : {32'($urandom), blk[nxt][31:0]};
            else msg_word = {32'($urandom), 32'($urandom)};
            #1;
            if (msg_ready && nxt < 16) nxt++;
            phs = w_valid && w_ready;
            pv = w_valid;
            pw = w_word;
            pi = w_idx;
            if (phs) hs_cnt++;
        end
        if (!got_done) chk("timeout", {66'b0, got_done}, 67'd1);
        start = 1'b0;
        @(negedge clk);
        chk("done_pulse", {66'b0, done}, 67'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_msg_ready", {66'b0, msg_ready}, 67'd0);
        chk("rst_w_valid", {66'b0, w_valid}, 67'd0);
        chk("rst_w_word", w_word, 67'd0);
        chk("rst_w_idx", 67'(w_idx), 67'd0);
        chk("rst_busy", {66'b0, busy}, 67'd0);
        chk("rst_done", {66'b0, done}, 67'd0);
        rst = 1'b0;
        run_block(1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_block(1'b1, 1'b0, 1'b0, -1, 1'b0);
        run_block(1'b0, 1'b1, 1'b0, -1, 1'b0);
        run_block(1'b1, 1'b1, 1'b0, -1, 1'b0);
        run_block(1'b1, 1'b1, 1'b1, -1, 1'b0);
        run_block(1'b0, 1'b1, 1'b1, -1, 1'b0);
        run_block(1'b1, 1'b1, 1'b0, 40, 1'b0);
        run_block(1'b1, 1'b1, 1'b0, -1, 1'b1);
        run_block(1'b0, 1'b1, 1'b1, -1, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
